uart_tx_param: RTL and testbench

Parametrised UART serial transmitter, the successor to the fixed 8-bit UART1 transmit path.
- Accepts a parallel word over a valid/ready handshake and emits one framed serial bit stream, LSB first.
- Frame: start bit, DATA_W data bits, optional even/odd parity bit, one or two stop bits.
- Each bit is held for CLKS_PER_BIT clocks; the block sits between the transmit-side register interface and the serial pin.

---
 rtl/uart_tx_param.sv | 155 +++++++++++++++
 tb/tb_uart_tx_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Purpose : parametrised UART transmitter; start, DATA_W data bits LSB first, optional parity, 1/2 stop.
// Latency : serial line leaves idle the cycle after the handshake; frame = (1+DATA_W+P+S)*CLKS_PER_BIT cycles.
// Backpr. : o_tx_ready is high only in IDLE; i_tx_valid is ignored while a frame is in flight.
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   i_tx_data        word to send, sampled on the handshake edge
//   i_tx_valid       source has a word;  o_tx_ready  block can accept a word
//   i_parity_mode    00/11 none, 01 even, 10 odd; sampled on handshake
//   i_stop2          0 one stop bit, 1 two stop bits; sampled on handshake
//   o_serial_out     registered serial line (idle high)
//   o_busy           frame in progress;  o_done  pulse in the last cycle of the final stop bit
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic [1:0]        i_parity_mode,
  input  logic              i_stop2,
  output logic              o_serial_out,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        r_state;
  logic [BW-1:0]     r_baud;
  logic [IW-1:0]     r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_stop2;
  logic              r_stop_cnt;
  logic              r_serial;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic w_bit_end;
  logic w_last_data;
  logic w_last_stop;

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_last_data = (r_bit_idx == IDX_LAST);
  // r_stop_cnt counts stop bits already completed; the last one is index r_stop2.
  assign w_last_stop = (r_stop_cnt == r_stop2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_serial   <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (i_tx_valid) begin
          r_shift    <= i_tx_data;
          r_par_en   <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
          // Odd parity is the inverse of the XOR reduction of the word.
          r_par_bit  <= (^i_tx_data) ^ (i_parity_mode == 2'b10);
          r_stop2    <= i_stop2;
          r_stop_cnt <= 1'b0;
          r_baud     <= '0;
          r_bit_idx  <= '0;
          r_state    <= S_START;
          r_serial   <= 1'b0;
          r_ready    <= 1'b0;
          r_busy     <= 1'b1;
        end
      end else begin
        r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
        // Registered pulse: set one cycle early so it lands on the final cycle of the frame.
        if (r_state == S_STOP && w_last_stop && r_baud == BAUD_PRE) begin
          r_done <= 1'b1;
        end
        if (w_bit_end) begin
          case (r_state)
            S_START: begin
              r_state  <= S_DATA;
              r_serial <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
            S_DATA: begin
              if (w_last_data) begin
                r_bit_idx <= '0;
                if (r_par_en) begin
                  r_state  <= S_PARITY;
                  r_serial <= r_par_bit;
                end else begin
                  r_state  <= S_STOP;
                  r_serial <= 1'b1;
                end
              end else begin
                r_bit_idx <= r_bit_idx + IW'(1);
                r_serial  <= r_shift[0];
                r_shift   <= r_shift >> 1;
              end
            end
            S_PARITY: begin
              r_state  <= S_STOP;
              r_serial <= 1'b1;
            end
            S_STOP: begin
              if (w_last_stop) begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_stop_cnt <= 1'b1;
              end
              r_serial <= 1'b1;
            end
            default: begin
              r_state  <= S_IDLE;
              r_serial <= 1'b1;
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign o_serial_out = r_serial;
  assign o_tx_ready   = r_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: DATA_W=8, CLKS_PER_BIT=4.  Instance 1: DATA_W=5, CLKS_PER_BIT=2.
  logic [7:0] d8;  logic v8;  logic [1:0] m8;  logic s8;
  logic rdy8, ser8, bsy8, dn8;
  logic [4:0] d5;  logic v5;  logic [1:0] m5;  logic s5;
  logic rdy5, ser5, bsy5, dn5;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut8 (
    .clk(clk), .rst(rst), .i_tx_data(d8), .i_tx_valid(v8), .o_tx_ready(rdy8),
    .i_parity_mode(m8), .i_stop2(s8), .o_serial_out(ser8), .o_busy(bsy8), .o_done(dn8)
  );

  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(2)) u_dut5 (
    .clk(clk), .rst(rst), .i_tx_data(d5), .i_tx_valid(v5), .o_tx_ready(rdy5),
    .i_parity_mode(m5), .i_stop2(s5), .o_serial_out(ser5), .o_busy(bsy5), .o_done(dn5)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {serial, busy, ready, done}
  function automatic logic [3:0] obs(input int sel);
    return (sel == 1) ? {ser5, bsy5, rdy5, dn5} : {ser8, bsy8, rdy8, dn8};
  endfunction

  // Reference line waveform, one entry per clock after the handshake edge.
  function automatic void build_frame(input int dw, input int cpb, input int data,
                                      input int mode, input bit st2);
    bit par;
    bit par_en;
    exp_q.delete();
    par = 1'b0;
    for (int i = 0; i < dw; i++) par ^= bit'((data >> i) & 1);
    par_en = (mode == 1) || (mode == 2);
    if (mode == 2) par = ~par;
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++)
      for (int c = 0; c < cpb; c++) exp_q.push_back(bit'((data >> i) & 1));
    if (par_en)
      for (int c = 0; c < cpb; c++) exp_q.push_back(par);
    for (int c = 0; c < (st2 ? 2 : 1) * cpb; c++) exp_q.push_back(1'b1);
  endfunction

  task automatic drive(input int sel, input bit v, input int d, input int m, input bit s);
    if (sel == 1) begin
      v5 = v; d5 = 5'(d); m5 = 2'(m); s5 = s;
    end else begin
      v8 = v; d8 = 8'(d); m8 = 2'(m); s8 = s;
    end
  endtask

  // Entered just after a negedge. Sends one frame and checks every cycle of it plus the
  // following idle cycle. Mid-frame the inputs are scrambled (if scr) and finally set to
  // the next frame's values (nv = hold valid for a back-to-back frame).
  task automatic send_frame(input int sel, input int d, input int m, input bit s,
                            input bit nv, input int nd, input int nm, input bit ns,
                            input bit scr);
    int dw;
    int cpb;
    int w;
    int len;
    dw  = (sel == 1) ? 5 : 8;
    cpb = (sel == 1) ? 2 : 4;
    build_frame(dw, cpb, d, m, s);
    len = exp_q.size();
    drive(sel, 1'b1, d, m, s);
    w = 0;
    while (obs(sel)[1] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("hs_ready", 32'(obs(sel)[1]), 32'd1);
    @(posedge clk);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check_eq($sformatf("frame sel%0d d%0h k%0d", sel, d, k), 32'(obs(sel)),
               32'({exp_q[k], 1'b1, 1'b0, (k == len - 1)}));
      if (scr && k != len - 1)
        drive(sel, bit'($urandom_range(0, 1)), int'($urandom), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)));
      else
        drive(sel, nv, nd, nm, ns);
    end
    @(negedge clk);
    check_eq($sformatf("idle sel%0d", sel), 32'(obs(sel)), 32'b1010);
  endtask

  initial begin
    int d;
    int cur_d;
    int cur_m;
    bit cur_s;
    int nxt_d;
    int nxt_m;
    bit nxt_s;
    bit b2b;
    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst8", 32'(obs(0)), 32'b1010);
    check_eq("rst5", 32'(obs(1)), 32'b1010);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst8", 32'(obs(0)), 32'b1010);

    // Directed frames on the 8-bit instance.
    send_frame(0, 'hA5, 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    send_frame(0, 'hA5, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    send_frame(0, 'h3C, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    // Back-to-back with valid held high; data switches to 0x80 during the first frame.
    send_frame(0, 'h01, 1, 1'b0, 1'b1, 'h80, 1, 1'b0, 1'b0);
    send_frame(0, 'h80, 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset during data bit 3 (clocks 17..20 after the handshake).
    d = 'h5A;
    drive(0, 1'b1, d, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 1'b0);
    repeat (17) @(negedge clk);
    check_eq("bit3_before_rst", 32'(obs(0)), 32'({d[3], 1'b1, 1'b0, 1'b0}));
    #2 rst = 1'b1;
    #1 check_eq("rst_async", 32'(obs(0)), 32'b1010);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold", 32'(obs(0)), 32'b1010);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_release", 32'(obs(0)), 32'b1010);
    send_frame(0, 'hC3, 2, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // 5-bit instance: parity_mode 11 means no parity; inputs toggle mid-frame.
    send_frame(1, 'h15, 3, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Randomised frames on both instances, with random back-to-back chaining.
    for (int sel = 0; sel < 2; sel++) begin
      cur_d = int'($urandom);
      cur_m = int'($urandom_range(0, 3));
      cur_s = bit'($urandom_range(0, 1));
      for (int n = 0; n < 14; n++) begin
        nxt_d = int'($urandom);
        nxt_m = int'($urandom_range(0, 3));
        nxt_s = bit'($urandom_range(0, 1));
        b2b   = bit'($urandom_range(0, 1));
        send_frame(sel, cur_d & ((sel == 1) ? 'h1F : 'hFF), cur_m, cur_s,
                   b2b, nxt_d & ((sel == 1) ? 'h1F : 'hFF), nxt_m, nxt_s,
                   bit'($urandom_range(0, 1)));
        if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
        cur_d = nxt_d;
        cur_m = nxt_m;
        cur_s = nxt_s;
      end
      drive(sel, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
